// File: rtl/mac_accumulator.sv
// Dot-product accumulator fed by an 8x8 unsigned array multiplier, valid/ready in and out.
// Build option: define SATURATE_EN to clamp the sum at all-ones on overflow instead of wrapping.

module multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] m,
    output logic        rout
);
    // Shift-and-add over the rows of the partial-product array
    always_comb begin
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) m = m + (16'(a) << i);
        end
    end

    assign rout = m[15];
endmodule

module mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    // state | meaning
    // ACCUM | accepting operand pairs
    // DRAIN | last pair is in stage 1, its product lands next edge
    // HOLD  | result presented until the output handshake
    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt;
    logic [7:0]       a_r, b_r;
    logic             v1, first1, last1;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             ovf_r, ovf_nxt;
    logic [ACC_W:0]   sum;
    logic [15:0]      p;
    logic             unused_rout;
    logic             accept;

    multiplier u_mult (
        .a    (a_r),
        .b    (b_r),
        .m    (p),
        .rout (unused_rout)
    );

    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        sum     = {1'b0, (first1 ? {ACC_W{1'b0}} : acc)} + {{(ACC_W-15){1'b0}}, p};
        ovf_nxt = (first1 ? 1'b0 : ovf_r) | sum[ACC_W];
`ifdef SATURATE_EN
        acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && cnt == LAST) state_d = DRAIN;
            DRAIN:   state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            v1      <= 1'b0;
            first1  <= 1'b0;
            last1   <= 1'b0;
            acc     <= '0;
            ovf_r   <= 1'b0;
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                a_r    <= in_a;
                b_r    <= in_b;
                first1 <= (cnt == '0);
                last1  <= (cnt == LAST);
                cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
            // Result register is separate so it survives the next result's accumulation
            if (v1) begin
                acc   <= acc_nxt;
                ovf_r <= ovf_nxt;
                if (last1) begin
                    out_acc <= acc_nxt;
                    out_ovf <= ovf_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: three instances (LEN=4/ACC_W=24, LEN=2/ACC_W=16, LEN=1/ACC_W=24).

module tb_mac_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0]      iv   = '0;
    logic [2:0]      ordy = '0;
    logic [2:0][7:0] ia   = '0;
    logic [2:0][7:0] ib   = '0;
    wire  [2:0]      ir, ovl, ovf;
    wire  [23:0]     acc0, acc2;
    wire  [15:0]     acc1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mac_accumulator #(.ACC_W(24), .LEN(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
        .out_valid(ovl[0]), .out_ready(ordy[0]), .out_acc(acc0), .out_ovf(ovf[0]));
    mac_accumulator #(.ACC_W(16), .LEN(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
        .out_valid(ovl[1]), .out_ready(ordy[1]), .out_acc(acc1), .out_ovf(ovf[1]));
    mac_accumulator #(.ACC_W(24), .LEN(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
        .out_valid(ovl[2]), .out_ready(ordy[2]), .out_acc(acc2), .out_ovf(ovf[2]));

    function automatic logic [31:0] acc_of(input int d);
        case (d)
            0:       return {8'd0, acc0};
            1:       return {16'd0, acc1};
            default: return {8'd0, acc2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input int d, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        iv[d] = 1'b1; ia[d] = a; ib[d] = b;
        while (!ir[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ir[d]) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        iv[d] = 1'b0; ia[d] = 8'($urandom); ib[d] = 8'($urandom);
    endtask

    task automatic wait_valid(input int d);
        int t = 0;
        while (!ovl[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ovl[d]) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic take(input int d, input string tag, input logic [31:0] ea, input logic eo);
        wait_valid(d);
        chk({tag, "_acc"}, acc_of(d), ea);
        chk({tag, "_ovf"}, 32'(ovf[d]), 32'(eo));
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk({tag, "_ready_after"}, 32'(ir[d]), 32'd1);
        chk({tag, "_valid_after"}, 32'(ovl[d]), 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_in_ready", 32'(ir), 32'd0);
        chk("rst_out_valid", 32'(ovl), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_acc0", acc_of(0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ir), 32'd7);
        @(negedge clk);

        // 1: basic dot product and latency
        send(0, 8'd1, 8'd1);
        send(0, 8'd2, 8'd3);
        send(0, 8'd255, 8'd255);
        send(0, 8'd0, 8'd200);
        chk("t1_drain_valid", 32'(ovl[0]), 32'd0);
        chk("t1_drain_ready", 32'(ir[0]), 32'd0);
        @(negedge clk);
        chk("t1_latency_valid", 32'(ovl[0]), 32'd1);
        take(0, "t1", 32'd65032, 1'b0);

        // 2: backpressure holds the result
        send(0, 8'd1, 8'd1);
        send(0, 8'd2, 8'd3);
        send(0, 8'd255, 8'd255);
        send(0, 8'd0, 8'd200);
        wait_valid(0);
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(ovl[0]), 32'd1);
            chk("t2_hold_acc", acc_of(0), 32'd65032);
            chk("t2_hold_ready", 32'(ir[0]), 32'd0);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        take(0, "t2", 32'd65032, 1'b0);

        // 3: overflow, then a clean result clears the flag
        send(1, 8'd255, 8'd255);
        send(1, 8'd255, 8'd255);
`ifdef SATURATE_EN
        take(1, "t3_ovf", 32'd65535, 1'b1);
`else
        take(1, "t3_ovf", 32'd64514, 1'b1);
`endif
        send(1, 8'd1, 8'd1);
        send(1, 8'd1, 8'd1);
        take(1, "t3_clean", 32'd2, 1'b0);

        // 4: reset in the middle of a result
        send(0, 8'd9, 8'd9);
        send(0, 8'd7, 8'd7);
        rst = 1'b1;
        #1;
        chk("t4_rst_ready", 32'(ir[0]), 32'd0);
        chk("t4_rst_valid", 32'(ovl[0]), 32'd0);
        chk("t4_rst_acc", acc_of(0), 32'd0);
        chk("t4_rst_ovf", 32'(ovf[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(0, 8'd1, 8'd1);
        take(0, "t4", 32'd4, 1'b0);

        // 5: bubbles between beats, garbage operands while idle
        for (int i = 0; i < 4; i++) begin
            send(0, 8'd3, 8'd5);
            repeat (2) @(negedge clk);
        end
        take(0, "t5", 32'd60, 1'b0);

        // 6: LEN=1, every beat is a result
        send(2, 8'd15, 8'd17);
        take(2, "t6_a", 32'd255, 1'b0);
        send(2, 8'd0, 8'd0);
        take(2, "t6_b", 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
